// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-latency data memory model.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: FSM state encoding, LFSR seed/tap constants, byte-lane merge helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10 of a left shifter.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Widest data word the merge helper handles; callers zero-extend and truncate.
  localparam int MAX_DW = 256;
  localparam int MAX_BW = MAX_DW / 8;

  // Replace each byte of old_w whose lane enable is set with the byte from new_w.
  function automatic logic [MAX_DW-1:0] lanes_merge(input logic [MAX_DW-1:0] old_w,
                                                     input logic [MAX_DW-1:0] new_w,
                                                     input logic [MAX_BW-1:0] be);
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_BW; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_latency_lfsr.sv
// Pseudo-random latency source: 16-bit Fibonacci LFSR that advances only when stepped.
// Latency: value reflects the step one cycle later; reset loads the fixed seed.
// Backpressure: none; step is a plain enable.
// Ports: CLK, RSTn (async active-low), step (advance one position), value (current state).
// Only built when DMEM_RANDOM_LATENCY_EN is defined.
`ifdef DMEM_RANDOM_LATENCY_EN
module dmem_latency_lfsr
  import dmem_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] lfsr;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign value = lfsr;

endmodule
`endif

// File: rtl/dmem_multi_latency.sv
// Single-port data memory with programmable access latency and READY handshake.
// Latency: L = max(LATENCY,1) cycles from acceptance to completion; L=1 never drops READY.
// Backpressure: READY=0 while busy; requests presented then are ignored (request is latched).
// Ports: CLK, RSTn (async active-low), CSN/WEN (active-low select / write), ADDR, BE, DI,
//        LATENCY in; DOUT (read data, held), READY, ERR (out-of-range pulse on completion) out.
// Option: DMEM_RANDOM_LATENCY_EN replaces LATENCY with an LFSR-derived latency.
module dmem_multi_latency
  import dmem_pkg::*;
#(
  parameter int    DWIDTH   = 32,
  parameter int    AWIDTH   = 12,
  parameter int    SIZE     = 4096,
  parameter int    LWIDTH   = 3,
  parameter string INITFILE = "",
  localparam int   BWIDTH   = DWIDTH / 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              CSN,
  input  logic              WEN,
  input  logic [AWIDTH-1:0] ADDR,
  input  logic [BWIDTH-1:0] BE,
  input  logic [DWIDTH-1:0] DI,
  input  logic [LWIDTH-1:0] LATENCY,
  output logic [DWIDTH-1:0] DOUT,
  output logic              READY,
  output logic              ERR
);

  logic [DWIDTH-1:0] mem [SIZE];

  // Power-up image of the model; contents are deliberately untouched by reset.
  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = '0;
  end

  state_t            state, state_nxt;
  logic [LWIDTH-1:0] cnt, cnt_nxt;
  logic [AWIDTH-1:0] req_addr;
  logic              req_wen;
  logic [BWIDTH-1:0] req_be;
  logic [DWIDTH-1:0] req_di;

  logic              accept;
  logic              complete;
  logic [LWIDTH-1:0] lat_req;
  logic [LWIDTH-1:0] lat_eff;

`ifdef DMEM_RANDOM_LATENCY_EN
  logic [15:0] lfsr_val;
  logic        unused_lat;

  dmem_latency_lfsr u_lfsr (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .step  (accept),
    .value (lfsr_val)
  );

  assign lat_req    = LWIDTH'(1 + (int'(lfsr_val[LWIDTH-1:0]) % ((1 << LWIDTH) - 1)));
  assign unused_lat = ^{LATENCY, lfsr_val[15:LWIDTH]};
`else
  assign lat_req = LATENCY;
`endif

  assign lat_eff = (lat_req == '0) ? LWIDTH'(1) : lat_req;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (!CSN) begin
          accept = 1'b1;
          if (lat_eff == LWIDTH'(1)) begin
            state_nxt = DONE;
            complete  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = lat_eff - LWIDTH'(1);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        // cnt<=1 rather than ==1 so a corrupted zero count cannot wedge the FSM.
        if (cnt <= LWIDTH'(1)) begin
          state_nxt = DONE;
          complete  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - LWIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A one-cycle access completes on its own acceptance edge, so it must use the
  // live inputs; longer accesses complete from the latched copy.
  logic [AWIDTH-1:0] cmp_addr;
  logic              cmp_wen;
  logic [BWIDTH-1:0] cmp_be;
  logic [DWIDTH-1:0] cmp_di;
  logic              in_range;

  assign cmp_addr = accept ? ADDR : req_addr;
  assign cmp_wen  = accept ? WEN  : req_wen;
  assign cmp_be   = accept ? BE   : req_be;
  assign cmp_di   = accept ? DI   : req_di;
  assign in_range = (32'(cmp_addr) < SIZE);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      cnt      <= '0;
      req_addr <= '0;
      req_wen  <= 1'b1;
      req_be   <= '0;
      req_di   <= '0;
      DOUT     <= '0;
      ERR      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        req_addr <= ADDR;
        req_wen  <= WEN;
        req_be   <= BE;
        req_di   <= DI;
      end
      ERR <= complete && !in_range;
      if (complete && cmp_wen) begin
        DOUT <= in_range ? mem[cmp_addr] : '0;
      end
    end
  end

  // Writes commit only at completion; reset returns the FSM to IDLE, so an
  // aborted access never reaches this point.
  always_ff @(posedge CLK) begin
    if (complete && !cmp_wen && in_range) begin
      mem[cmp_addr] <= DWIDTH'(lanes_merge(MAX_DW'(mem[cmp_addr]), MAX_DW'(cmp_di),
                                           MAX_BW'(cmp_be)));
    end
  end

  assign READY = (state != BUSY);

endmodule

// File: tb/tb_dmem_multi_latency.sv
// Directed bench for dmem_multi_latency (SIZE=4000 instance).
// Default build: latency timing, byte lanes, reset abort, out-of-range handling.
// With DMEM_RANDOM_LATENCY_EN: LFSR latency sequence and its reproducibility.
module tb_dmem_multi_latency;

  logic        CLK;
  logic        RSTn;
  logic        CSN;
  logic        WEN;
  logic [11:0] ADDR;
  logic [3:0]  BE;
  logic [31:0] DI;
  logic [2:0]  LATENCY;
  logic [31:0] DOUT;
  logic        READY;
  logic        ERR;

  int errors = 0;
  int checks = 0;

  dmem_multi_latency #(
    .DWIDTH (32),
    .AWIDTH (12),
    .SIZE   (4000),
    .LWIDTH (3)
  ) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .CSN     (CSN),
    .WEN     (WEN),
    .ADDR    (ADDR),
    .BE      (BE),
    .DI      (DI),
    .LATENCY (LATENCY),
    .DOUT    (DOUT),
    .READY   (READY),
    .ERR     (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic csn, input logic wen, input logic [11:0] addr,
                       input logic [3:0] be, input logic [31:0] di, input logic [2:0] lat);
    CSN     = csn;
    WEN     = wen;
    ADDR    = addr;
    BE      = be;
    DI      = di;
    LATENCY = lat;
  endtask

`ifdef DMEM_RANDOM_LATENCY_EN
  int lens [2][50];

  task automatic run_reads(input int run);
    int c;
    drive(1'b0, 1'b1, 12'd5, 4'h0, 32'h0, 3'd0);
    for (int n = 0; n < 50; n++) begin
      c = 0;
      tick;
      while (READY !== 1'b1 && c < 20) begin
        tick;
        c++;
      end
      lens[run][n] = c;
    end
    drive(1'b1, 1'b1, 12'd0, 4'h0, 32'h0, 3'd0);
    tick;
  endtask
`endif

  initial begin
    drive(1'b1, 1'b1, 12'd0, 4'h0, 32'h0, 3'd1);
    RSTn = 1'b0;
    tick;
    tick;
    check("rst_ready", 32'(READY), 32'd1);
    check("rst_dout", DOUT, 32'h0);
    check("rst_err", 32'(ERR), 32'd0);
    RSTn = 1'b1;
    tick;

`ifdef DMEM_RANDOM_LATENCY_EN
    begin
      logic [15:0] lf;
      run_reads(0);
      RSTn = 1'b0;
      tick;
      RSTn = 1'b1;
      tick;
      run_reads(1);
      lf = 16'hACE1;
      for (int n = 0; n < 50; n++) begin
        check($sformatf("t6_len%0d", n), 32'(lens[0][n]), 32'(int'(lf[2:0]) % 7));
        check($sformatf("t6_max%0d", n), 32'(lens[0][n] <= 6), 32'd1);
        check($sformatf("t6_rerun%0d", n), 32'(lens[1][n]), 32'(lens[0][n]));
        lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
      end
    end
`else
    // 1: single-cycle write then read, READY never drops
    drive(1'b0, 1'b0, 12'd5, 4'hF, 32'hDEADBEEF, 3'd1);
    tick;
    check("t1_wr_ready", 32'(READY), 32'd1);
    check("t1_wr_dout", DOUT, 32'h0);
    drive(1'b0, 1'b1, 12'd5, 4'h0, 32'h0, 3'd1);
    tick;
    check("t1_rd_ready", 32'(READY), 32'd1);
    check("t1_rd_dout", DOUT, 32'hDEADBEEF);

    // 2: latency 4, inputs scrambled while busy
    drive(1'b0, 1'b1, 12'd6, 4'h0, 32'h0, 3'd1);
    tick;
    check("t2_pre_dout", DOUT, 32'h0);
    drive(1'b0, 1'b1, 12'd5, 4'h0, 32'h0, 3'd4);
    tick;
    drive(1'b1, 1'b1, 12'd6, 4'h0, 32'h0, 3'd1);
    check("t2_busy1", 32'(READY), 32'd0);
    check("t2_busy1_dout", DOUT, 32'h0);
    tick;
    check("t2_busy2", 32'(READY), 32'd0);
    tick;
    check("t2_busy3", 32'(READY), 32'd0);
    tick;
    check("t2_done_ready", 32'(READY), 32'd1);
    check("t2_done_dout", DOUT, 32'hDEADBEEF);
    tick;
    check("t2_idle_ready", 32'(READY), 32'd1);

    // 3: partial byte enables and BE=0 write
    drive(1'b0, 1'b0, 12'd5, 4'b0101, 32'h11223344, 3'd1);
    tick;
    check("t3_wr_dout_held", DOUT, 32'hDEADBEEF);
    drive(1'b0, 1'b1, 12'd5, 4'h0, 32'h0, 3'd1);
    tick;
    check("t3_rd_merge", DOUT, 32'hDE22BE44);
    drive(1'b0, 1'b0, 12'd5, 4'h0, 32'hFFFFFFFF, 3'd1);
    tick;
    drive(1'b0, 1'b1, 12'd5, 4'h0, 32'h0, 3'd1);
    tick;
    check("t3_be0", DOUT, 32'hDE22BE44);

    // 4: reset during a pending write
    drive(1'b0, 1'b0, 12'd7, 4'hF, 32'hCAFEF00D, 3'd1);
    tick;
    drive(1'b0, 1'b0, 12'd7, 4'hF, 32'h12345678, 3'd3);
    tick;
    drive(1'b1, 1'b1, 12'd0, 4'h0, 32'h0, 3'd1);
    check("t4_busy", 32'(READY), 32'd0);
    #1 RSTn = 1'b0;
    #1 check("t4_async_ready", 32'(READY), 32'd1);
    tick;
    tick;
    RSTn = 1'b1;
    check("t4_rst_dout", DOUT, 32'h0);
    drive(1'b0, 1'b1, 12'd7, 4'h0, 32'h0, 3'd1);
    tick;
    check("t4_old_value", DOUT, 32'hCAFEF00D);

    // 5: out-of-range read and write
    drive(1'b0, 1'b1, 12'd4000, 4'h0, 32'h0, 3'd2);
    tick;
    drive(1'b1, 1'b1, 12'd0, 4'h0, 32'h0, 3'd1);
    check("t5_busy_err", 32'(ERR), 32'd0);
    tick;
    check("t5_rd_err", 32'(ERR), 32'd1);
    check("t5_rd_dout", DOUT, 32'h0);
    check("t5_rd_ready", 32'(READY), 32'd1);
    tick;
    check("t5_err_clr", 32'(ERR), 32'd0);
    drive(1'b0, 1'b0, 12'd4000, 4'hF, 32'hA5A5A5A5, 3'd1);
    tick;
    check("t5_wr_err", 32'(ERR), 32'd1);
    drive(1'b0, 1'b1, 12'd7, 4'h0, 32'h0, 3'd1);
    tick;
    check("t5_after_err", 32'(ERR), 32'd0);
    check("t5_mem_intact", DOUT, 32'hCAFEF00D);
    drive(1'b0, 1'b1, 12'd4000, 4'h0, 32'h0, 3'd1);
    tick;
    check("t5_rd_again", DOUT, 32'h0);
    drive(1'b1, 1'b1, 12'd0, 4'h0, 32'h0, 3'd1);
    tick;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
